multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the csRISC core: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back. It drives the 3-bit `ALUop` consumed by the ALU control decoder, plus the register-file, PC and memory enables. It also handles the single-port memory request/acknowledge handshake and counts retired instructions. It sits between the instruction register and the datapath muxes.

---
 rtl/csrisc_pkg.sv | 50 +++++
 rtl/ctrl_decode.sv | 54 +++++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csrisc_pkg.sv
// csRISC shared definitions: opcodes, ALU operation classes,
// control FSM states and the decoded-instruction bundle.
package csrisc_pkg;

   localparam logic [5:0] OP_RARITH = 6'd0;
   localparam logic [5:0] OP_ADDI   = 6'd1;
   localparam logic [5:0] OP_RLOGIC = 6'd2;
   localparam logic [5:0] OP_COMPI  = 6'd3;
   localparam logic [5:0] OP_SHIFT  = 6'd4;
   localparam logic [5:0] OP_LW     = 6'd5;
   localparam logic [5:0] OP_SW     = 6'd6;
   localparam logic [5:0] OP_BZ     = 6'd7;
   localparam logic [5:0] OP_HALT   = 6'd8;

   localparam logic [2:0] ALU_ARITH = 3'b000;
   localparam logic [2:0] ALU_ADDI  = 3'b010;
   localparam logic [2:0] ALU_LOGIC = 3'b011;
   localparam logic [2:0] ALU_COMP  = 3'b100;
   localparam logic [2:0] ALU_SHIFT = 3'b101;
   localparam logic [2:0] ALU_MEM   = 3'b110;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU,
      CL_MEM,
      CL_BR,
      CL_HALT,
      CL_ILL
   } op_class_t;

   typedef struct packed {
      op_class_t  cls;
      logic [2:0] aluop;
      logic       alu_src_imm;
      logic       is_mem;
      logic       is_store;
      logic       is_branch;
      logic       is_halt;
      logic       is_illegal;
   } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier for the csRISC control FSM.
// Unknown opcodes fall into the illegal class.
module ctrl_decode
   import csrisc_pkg::*;
(
   input  logic [5:0] i_opcode,
   output dec_t       o_dec
);

   always_comb begin
      o_dec     = '0;
      o_dec.cls = CL_ALU;
      case (i_opcode)
         OP_RARITH: o_dec.aluop = ALU_ARITH;
         OP_ADDI: begin
            o_dec.aluop       = ALU_ADDI;
            o_dec.alu_src_imm = 1'b1;
         end
         OP_RLOGIC: o_dec.aluop = ALU_LOGIC;
         OP_COMPI: begin
            o_dec.aluop       = ALU_COMP;
            o_dec.alu_src_imm = 1'b1;
         end
         OP_SHIFT: o_dec.aluop = ALU_SHIFT;
         OP_LW: begin
            o_dec.cls         = CL_MEM;
            o_dec.aluop       = ALU_MEM;
            o_dec.alu_src_imm = 1'b1;
            o_dec.is_mem      = 1'b1;
         end
         OP_SW: begin
            o_dec.cls         = CL_MEM;
            o_dec.aluop       = ALU_MEM;
            o_dec.alu_src_imm = 1'b1;
            o_dec.is_mem      = 1'b1;
            o_dec.is_store    = 1'b1;
         end
         OP_BZ: begin
            o_dec.cls       = CL_BR;
            o_dec.aluop     = ALU_ARITH;
            o_dec.is_branch = 1'b1;
         end
         OP_HALT: begin
            o_dec.cls     = CL_HALT;
            o_dec.is_halt = 1'b1;
         end
         default: begin
            o_dec.cls        = CL_ILL;
            o_dec.is_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// csRISC multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing,
// memory handshake, sticky illegal flag and retired-instruction counter.
module multicycle_ctrl
   import csrisc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_load,
   output logic             pc_write,
   output logic             pc_src,
   output logic             alu_src_imm,
   output logic [2:0]       ALUop,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   state_t           r_state;
   state_t           w_next;
   dec_t             w_dec;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;

   logic       w_retire;
   logic       w_set_ill;
   logic       w_mem_req;
   logic       w_mem_we;
   logic       w_iord;
   logic       w_ir_load;
   logic       w_pc_write;
   logic       w_pc_src;
   logic       w_imm;
   logic [2:0] w_aluop;
   logic       w_reg_write;
   logic       w_mem_to_reg;

   ctrl_decode u_dec (
      .i_opcode (opcode),
      .o_dec    (w_dec)
   );

   always_comb begin
      w_next       = r_state;
      w_retire     = 1'b0;
      w_set_ill    = 1'b0;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_iord       = 1'b0;
      w_ir_load    = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 1'b0;
      w_imm        = 1'b0;
      w_aluop      = ALU_ARITH;
      w_reg_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      unique case (r_state)
         ST_FETCH: begin
            w_mem_req = 1'b1;
            if (mem_ack) begin
               w_ir_load  = 1'b1;
               w_pc_write = 1'b1;
               w_next     = ST_DECODE;
            end
         end
         ST_DECODE: begin
            // unknown opcodes retire as a nop and latch the sticky flag
            if (w_dec.is_illegal) begin
               w_set_ill = 1'b1;
               w_retire  = 1'b1;
               w_next    = ST_FETCH;
            end else if (w_dec.is_halt) begin
               w_next = ST_HALT;
            end else begin
               w_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            w_aluop = w_dec.aluop;
            w_imm   = w_dec.alu_src_imm;
            if (w_dec.is_branch) begin
               w_pc_write = zero;
               w_pc_src   = 1'b1;
               w_retire   = 1'b1;
               w_next     = ST_FETCH;
            end else if (w_dec.is_mem) begin
               w_next = ST_MEM;
            end else begin
               w_next = ST_WB;
            end
         end
         ST_MEM: begin
            w_mem_req = 1'b1;
            w_iord    = 1'b1;
            w_mem_we  = w_dec.is_store;
            if (mem_ack) begin
               if (w_dec.is_store) begin
                  w_retire = 1'b1;
                  w_next   = ST_FETCH;
               end else begin
                  w_next = ST_WB;
               end
            end
         end
         ST_WB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = (w_dec.cls == CL_MEM);
            w_retire     = 1'b1;
            w_next       = ST_FETCH;
         end
         ST_HALT: w_next = ST_HALT;
         default: w_next = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_FETCH;
         r_illegal <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (w_set_ill)
            r_illegal <= 1'b1;
         if (w_retire)
            r_retired <= r_retired + CNT_W'(1);
      end
   end

   // reset silences everything in its own cycle, abandoning any request
   assign mem_req     = w_mem_req    & ~rst;
   assign mem_we      = w_mem_we     & ~rst;
   assign iord        = w_iord       & ~rst;
   assign ir_load     = w_ir_load    & ~rst;
   assign pc_write    = w_pc_write   & ~rst;
   assign pc_src      = w_pc_src     & ~rst;
   assign alu_src_imm = w_imm        & ~rst;
   assign ALUop       = w_aluop      & {3{~rst}};
   assign reg_write   = w_reg_write  & ~rst;
   assign mem_to_reg  = w_mem_to_reg & ~rst;
   assign illegal     = r_illegal    & ~rst;
   assign halted      = (r_state == ST_HALT) & ~rst;
   assign retired     = rst ? '0 : r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second narrow-counter
// instance shares the stimulus to exercise counter wrap.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ack;

   logic        mem_req, mem_we, iord, ir_load, pc_write, pc_src;
   logic        alu_src_imm, reg_write, mem_to_reg, illegal, halted;
   logic [2:0]  ALUop;
   logic [31:0] retired;

   logic        w2_mem_req, w2_mem_we, w2_iord, w2_ir_load, w2_pc_write;
   logic        w2_pc_src, w2_imm, w2_reg_write, w2_mem_to_reg;
   logic        w2_illegal, w2_halted;
   logic [2:0]  w2_aluop;
   logic [2:0]  w2_retired;

   logic [11:0] ctl, ctl2;

   int n_chk  = 0;
   int n_pass = 0;
   int n_ret  = 0;

   localparam logic [11:0] F_ACK  = 12'b1_0_0_1_1_0_0_000_0_0;
   localparam logic [11:0] F_WAIT = 12'b1_0_0_0_0_0_0_000_0_0;
   localparam logic [11:0] IDLE   = 12'b0_0_0_0_0_0_0_000_0_0;
   localparam logic [11:0] EX_IMM = 12'b0_0_0_0_0_0_1_010_0_0;
   localparam logic [11:0] EX_LOG = 12'b0_0_0_0_0_0_0_011_0_0;
   localparam logic [11:0] EX_CMP = 12'b0_0_0_0_0_0_1_100_0_0;
   localparam logic [11:0] EX_SHF = 12'b0_0_0_0_0_0_0_101_0_0;
   localparam logic [11:0] EX_MEM = 12'b0_0_0_0_0_0_1_110_0_0;
   localparam logic [11:0] EX_BT  = 12'b0_0_0_0_1_1_0_000_0_0;
   localparam logic [11:0] EX_BN  = 12'b0_0_0_0_0_1_0_000_0_0;
   localparam logic [11:0] MEM_L  = 12'b1_0_1_0_0_0_0_000_0_0;
   localparam logic [11:0] MEM_S  = 12'b1_1_1_0_0_0_0_000_0_0;
   localparam logic [11:0] WB_R   = 12'b0_0_0_0_0_0_0_000_1_0;
   localparam logic [11:0] WB_L   = 12'b0_0_0_0_0_0_0_000_1_1;

   localparam logic [5:0]  LO_OP [5] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd1};
   localparam logic [11:0] LO_EX [5] = '{IDLE, EX_LOG, EX_CMP, EX_SHF, EX_IMM};

   multicycle_ctrl u_dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ack     (mem_ack),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .iord        (iord),
      .ir_load     (ir_load),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .alu_src_imm (alu_src_imm),
      .ALUop       (ALUop),
      .reg_write   (reg_write),
      .mem_to_reg  (mem_to_reg),
      .illegal     (illegal),
      .halted      (halted),
      .retired     (retired)
   );

   multicycle_ctrl #(.CNT_W(3)) u_w (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ack     (mem_ack),
      .mem_req     (w2_mem_req),
      .mem_we      (w2_mem_we),
      .iord        (w2_iord),
      .ir_load     (w2_ir_load),
      .pc_write    (w2_pc_write),
      .pc_src      (w2_pc_src),
      .alu_src_imm (w2_imm),
      .ALUop       (w2_aluop),
      .reg_write   (w2_reg_write),
      .mem_to_reg  (w2_mem_to_reg),
      .illegal     (w2_illegal),
      .halted      (w2_halted),
      .retired     (w2_retired)
   );

   assign ctl  = {mem_req, mem_we, iord, ir_load, pc_write, pc_src,
                  alu_src_imm, ALUop, reg_write, mem_to_reg};
   assign ctl2 = {w2_mem_req, w2_mem_we, w2_iord, w2_ir_load, w2_pc_write,
                  w2_pc_src, w2_imm, w2_aluop, w2_reg_write, w2_mem_to_reg};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // entered at posedge+1: drive, settle, check, advance one cycle
   task automatic run(input string tag, input logic [5:0] op,
                      input logic ack, input logic z,
                      input logic [11:0] exp);
      opcode  = op;
      mem_ack = ack;
      zero    = z;
      #1;
      chk(tag, ctl, exp);
      chk({tag, "_w"}, ctl2, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ret(input string tag);
      chk(tag, retired, n_ret);
      chk({tag, "_w"}, w2_retired, n_ret % 8);
   endtask

   initial begin
      int bad;
      rst     = 1'b1;
      opcode  = 6'd0;
      zero    = 1'b0;
      mem_ack = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_ctl", ctl, IDLE);
      chk("rst_flags", {illegal, halted}, 2'b00);
      chk("rst_ret", retired, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run("addi_f", 6'd1, 1'b1, 1'b0, F_ACK);
      run("addi_d", 6'd1, 1'b1, 1'b0, IDLE);
      run("addi_e", 6'd1, 1'b1, 1'b0, EX_IMM);
      run("addi_w", 6'd1, 1'b1, 1'b0, WB_R);
      n_ret++;
      chk_ret("addi_ret");

      run("lw_f", 6'd5, 1'b1, 1'b0, F_ACK);
      run("lw_d", 6'd5, 1'b0, 1'b0, IDLE);
      run("lw_e", 6'd5, 1'b0, 1'b0, EX_MEM);
      run("lw_m0", 6'd5, 1'b0, 1'b0, MEM_L);
      run("lw_m1", 6'd5, 1'b0, 1'b0, MEM_L);
      chk_ret("lw_noret");
      run("lw_m2", 6'd5, 1'b1, 1'b0, MEM_L);
      run("lw_w", 6'd5, 1'b0, 1'b0, WB_L);
      n_ret++;
      chk_ret("lw_ret");

      run("sw_f", 6'd6, 1'b1, 1'b0, F_ACK);
      run("sw_d", 6'd6, 1'b1, 1'b0, IDLE);
      run("sw_e", 6'd6, 1'b1, 1'b0, EX_MEM);
      run("sw_m", 6'd6, 1'b1, 1'b0, MEM_S);
      n_ret++;
      chk_ret("sw_ret");

      run("bzt_f", 6'd7, 1'b1, 1'b1, F_ACK);
      run("bzt_d", 6'd7, 1'b0, 1'b1, IDLE);
      run("bzt_e", 6'd7, 1'b0, 1'b1, EX_BT);
      n_ret++;
      chk_ret("bzt_ret");
      run("bzn_f", 6'd7, 1'b1, 1'b0, F_ACK);
      run("bzn_d", 6'd7, 1'b0, 1'b0, IDLE);
      run("bzn_e", 6'd7, 1'b0, 1'b0, EX_BN);
      n_ret++;
      chk_ret("bzn_ret");

      for (int i = 0; i < 5; i++) begin
         if (i == 0)
            run("alu_fw", LO_OP[i], 1'b0, 1'b0, F_WAIT);
         run("alu_f", LO_OP[i], 1'b1, 1'b0, F_ACK);
         run("alu_d", LO_OP[i], 1'b0, 1'b0, IDLE);
         run("alu_e", LO_OP[i], 1'b0, 1'b0, LO_EX[i]);
         run("alu_w", LO_OP[i], 1'b0, 1'b0, WB_R);
         n_ret++;
         chk_ret("alu_ret");
      end

      chk("ill_pre", illegal, 1'b0);
      run("ill_f", 6'h3F, 1'b1, 1'b0, F_ACK);
      run("ill_d", 6'h3F, 1'b1, 1'b0, IDLE);
      n_ret++;
      chk("ill_set", {illegal, w2_illegal}, 2'b11);
      chk_ret("ill_ret");
      run("ia_f", 6'd1, 1'b1, 1'b0, F_ACK);
      run("ia_d", 6'd1, 1'b0, 1'b0, IDLE);
      run("ia_e", 6'd1, 1'b0, 1'b0, EX_IMM);
      run("ia_w", 6'd1, 1'b0, 1'b0, WB_R);
      n_ret++;
      chk("ill_sticky", illegal, 1'b1);
      chk_ret("ia_ret");

      run("rsw_f", 6'd6, 1'b1, 1'b0, F_ACK);
      run("rsw_d", 6'd6, 1'b0, 1'b0, IDLE);
      run("rsw_e", 6'd6, 1'b0, 1'b0, EX_MEM);
      run("rsw_m", 6'd6, 1'b0, 1'b0, MEM_S);
      rst = 1'b1;
      #1;
      chk("rst_mid", ctl, IDLE);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      n_ret  = 0;
      opcode = 6'd6;
      #1;
      chk("rst_ill", {illegal, w2_illegal}, 2'b00);
      chk_ret("rst_ret");
      #1;
      run("rst_f", 6'd6, 1'b0, 1'b0, F_WAIT);

      run("hlt_f", 6'd8, 1'b1, 1'b0, F_ACK);
      run("hlt_d", 6'd8, 1'b1, 1'b0, IDLE);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         mem_ack = i[0];
         #1;
         if (ctl !== IDLE || halted !== 1'b1 || w2_halted !== 1'b1)
            bad++;
         @(posedge clk);
         #1;
      end
      chk("halt_hold", bad, 0);
      chk_ret("halt_ret");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("halt_exit", {halted, w2_halted}, 2'b00);
      chk_ret("halt_rst_ret");
      #1;
      run("post_f", 6'd1, 1'b0, 1'b0, F_WAIT);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
